// File: rtl/ant_batch_engine.sv
`default_nettype none
// ============================================================================
// ant_batch_engine : walks enabled ants, loading, erasing, bouncing,
//                    writing back and redrawing each via the datapath.
// Revision: 1.0
// ============================================================================
module ant_batch_engine #(
    parameter int NUM_ANTS          = 4,
    parameter int ID_WIDTH          = 2,
    parameter int X_WIDTH           = 8,
    parameter int Y_WIDTH           = 7,
    parameter int X_MAX             = 156,
    parameter int Y_MAX             = 116,
    parameter int COLOUR_WIDTH      = 3,
    parameter logic [COLOUR_WIDTH-1:0] COLOUR_FG = 3'd5,
    parameter logic [COLOUR_WIDTH-1:0] COLOUR_BG = '0,
    parameter int RESULT_WIDTH      = 16,
    parameter int INSTRUCTION_WIDTH = 24,
    parameter int ADDR_WIDTH        = 8,
    parameter int OPCODE_WIDTH      = 3,
    parameter logic [OPCODE_WIDTH-1:0] OPCODE_MEMREAD  = 3'd1,
    parameter logic [OPCODE_WIDTH-1:0] OPCODE_MEMWRITE = 3'd2,
    parameter logic [OPCODE_WIDTH-1:0] OPCODE_DRAW     = 3'd3,
    parameter logic [ADDR_WIDTH-1:0]   ADDR_ANT_BASE   = 8'h10
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [NUM_ANTS-1:0]          ant_mask,
    output logic                         finished,
    input  logic                         finished_dp,
    input  logic [RESULT_WIDTH-1:0]      result_dp,
    output logic                         start_dp,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_dp
);

    localparam int c_IDX_W = ID_WIDTH + 1;
    localparam logic [X_WIDTH-1:0] c_X_MAX    = X_WIDTH'(X_MAX);
    localparam logic [X_WIDTH-1:0] c_X_MAX_M1 = X_WIDTH'(X_MAX - 1);
    localparam logic [Y_WIDTH-1:0] c_Y_MAX    = Y_WIDTH'(Y_MAX);
    localparam logic [Y_WIDTH-1:0] c_Y_MAX_M1 = Y_WIDTH'(Y_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_START  = 3'd2,
        S_DELAY  = 3'd3,
        S_WAIT   = 3'd4,
        S_MOVE   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD_X  = 3'd0,
        OP_LOAD_Y  = 3'd1,
        OP_ERASE   = 3'd2,
        OP_MOVE    = 3'd3,
        OP_WRITE_X = 3'd4,
        OP_WRITE_Y = 3'd5,
        OP_DRAW    = 3'd6,
        OP_DONE    = 3'd7
    } op_t;

    state_t                         state_q, state_d;
    op_t                            op_q, op_d;
    logic [1:0]                     mode_q, mode_d;
    logic [NUM_ANTS-1:0]            mask_q, mask_d;
    logic [c_IDX_W-1:0]             idx_q, idx_d;
    logic [X_WIDTH-1:0]             x_q, x_d;
    logic [Y_WIDTH-1:0]             y_q, y_d;
    logic [NUM_ANTS-1:0]            dir_x_q, dir_x_d;
    logic [NUM_ANTS-1:0]            dir_y_q, dir_y_d;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
    logic                           finished_q, finished_d;

    logic [NUM_ANTS-1:0]            remaining;
    logic [ID_WIDTH-1:0]            id;
    logic [ADDR_WIDTH-1:0]          addr_x, addr_y;
    logic [X_WIDTH-1:0]             move_x;
    logic [Y_WIDTH-1:0]             move_y;
    logic                           move_dx, move_dy;
    logic                           load_instr;
    op_t                            op_next;
    logic                           unused_result_bits;

    assign unused_result_bits = ^result_dp[RESULT_WIDTH-1:X_WIDTH];

    // Mode 0 skips the move/write-back; mode 1 skips erase and redraw.
    function automatic op_t next_op(input op_t op, input logic [1:0] m);
        case (op)
            OP_LOAD_X:  return OP_LOAD_Y;
            OP_LOAD_Y:  return (m == 2'd0) ? OP_DRAW : ((m == 2'd1) ? OP_MOVE : OP_ERASE);
            OP_ERASE:   return OP_MOVE;
            OP_MOVE:    return OP_WRITE_X;
            OP_WRITE_X: return OP_WRITE_Y;
            OP_WRITE_Y: return (m == 2'd1) ? OP_DONE : OP_DRAW;
            default:    return OP_DONE;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            op_q       <= OP_LOAD_X;
            mode_q     <= '0;
            mask_q     <= '0;
            idx_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            dir_x_q    <= '1;
            dir_y_q    <= '1;
            instr_q    <= '0;
            finished_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mode_q     <= mode_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            instr_q    <= instr_d;
            finished_q <= finished_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mode_d     = mode_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        instr_d    = instr_q;
        finished_d = 1'b0;
        load_instr = 1'b0;
        op_next    = next_op(op_q, mode_q);

        remaining = mask_q >> idx_q;
        id        = idx_q[ID_WIDTH-1:0];
        addr_x    = ADDR_ANT_BASE + ADDR_WIDTH'({id, 1'b0});
        addr_y    = addr_x + ADDR_WIDTH'(1);

        // Bounce: at a wall the coordinate steps back inward, so an
        // out-of-range load is pulled into range rather than wrapping.
        if (dir_x_q[id]) begin
            move_x  = (x_q >= c_X_MAX) ? c_X_MAX_M1 : x_q + X_WIDTH'(1);
            move_dx = (x_q < c_X_MAX);
        end else begin
            move_x  = (x_q == '0) ? X_WIDTH'(1) : x_q - X_WIDTH'(1);
            move_dx = (x_q == '0);
        end
        if (dir_y_q[id]) begin
            move_y  = (y_q >= c_Y_MAX) ? c_Y_MAX_M1 : y_q + Y_WIDTH'(1);
            move_dy = (y_q < c_Y_MAX);
        end else begin
            move_y  = (y_q == '0) ? Y_WIDTH'(1) : y_q - Y_WIDTH'(1);
            move_dy = (y_q == '0);
        end

        case (state_q)
            S_IDLE: begin
                finished_d = !start;
                if (start) begin
                    mode_d  = mode;
                    mask_d  = ant_mask;
                    idx_d   = '0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                // No enabled ant at or above the index ends the run early.
                if (remaining == '0) begin
                    state_d = S_IDLE;
                end else if (!remaining[0]) begin
                    idx_d = idx_q + c_IDX_W'(1);
                end else begin
                    op_d       = OP_LOAD_X;
                    state_d    = S_START;
                    load_instr = 1'b1;
                end
            end
            S_START: state_d = S_DELAY;
            S_DELAY: state_d = S_WAIT;
            S_WAIT: begin
                if (finished_dp) begin
                    if (op_q == OP_LOAD_X) x_d = result_dp[X_WIDTH-1:0];
                    if (op_q == OP_LOAD_Y) y_d = result_dp[Y_WIDTH-1:0];
                    op_d = op_next;
                    if (op_next == OP_DONE) begin
                        idx_d   = idx_q + c_IDX_W'(1);
                        state_d = S_SELECT;
                    end else if (op_next == OP_MOVE) begin
                        state_d = S_MOVE;
                    end else begin
                        state_d    = S_START;
                        load_instr = 1'b1;
                    end
                end
            end
            S_MOVE: begin
                x_d          = move_x;
                y_d          = move_y;
                dir_x_d[id]  = move_dx;
                dir_y_d[id]  = move_dy;
                op_d         = OP_WRITE_X;
                state_d      = S_START;
                load_instr   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Encoded from next-cycle coordinates so a just-loaded y is used.
        if (load_instr) begin
            case (op_d)
                OP_LOAD_X:  instr_d = INSTRUCTION_WIDTH'({addr_x, OPCODE_MEMREAD});
                OP_LOAD_Y:  instr_d = INSTRUCTION_WIDTH'({addr_y, OPCODE_MEMREAD});
                OP_ERASE:   instr_d = INSTRUCTION_WIDTH'({1'b1, COLOUR_BG, y_d, x_d, OPCODE_DRAW});
                OP_WRITE_X: instr_d = INSTRUCTION_WIDTH'({x_d, addr_x, OPCODE_MEMWRITE});
                OP_WRITE_Y: instr_d = INSTRUCTION_WIDTH'({y_d, addr_y, OPCODE_MEMWRITE});
                OP_DRAW:    instr_d = INSTRUCTION_WIDTH'({1'b1, COLOUR_FG, y_d, x_d, OPCODE_DRAW});
                default:    instr_d = instr_q;
            endcase
        end
    end

    assign finished       = finished_q;
    assign start_dp       = (state_q == S_START) || (state_q == S_DELAY);
    assign instruction_dp = instr_q;

endmodule
`default_nettype wire
